// File: rtl/comb_differentiator.sv
`default_nettype none
// ============================================================================
//  Module      : comb_differentiator
//  Description : Streaming first-difference (comb) stage,
//                    y[n] = x[n] - x[n-DELAY]
//                on signed two's-complement samples. Sits downstream of
//                integrator chains (CIC decimation) or acts as a slope /
//                edge detector. Valid/ready handshakes on both sides and a
//                single registered output stage (one cycle of latency).
//
//  Parameters  : WIDTH  sample width in bits, signed (2..32)
//                DELAY  differential delay M in samples (1..8)
//
//  Ports       : clk         system clock, rising edge
//                reset       asynchronous active-high reset
//                clear       synchronous flush of history and output stage
//                in_data     signed input sample x[n]
//                in_valid    in_data valid
//                in_ready    block can accept a sample this cycle
//                out_data    signed difference y[n]
//                out_valid   out_data valid
//                out_ready   downstream accepts out_data
//                out_borrow  unsigned borrow of x[n] - x[n-DELAY]
//                out_ovf     signed overflow in the subtraction
//                out_warm    result produced before the history was full
//
//  Build option: COMB_DIFF_SATURATE_EN
//                  defined   -> overflowing results clamp to the signed
//                               maximum / minimum of WIDTH bits
//                  undefined -> overflowing results wrap (low WIDTH bits)
//
//  Revision    : 1.0  initial release
// ============================================================================
module comb_differentiator #(
    parameter int WIDTH = 16,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic             out_warm
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Fill counter only has to count up to DELAY, then it saturates.
    localparam int                    c_FILL_W    = $clog2(DELAY + 1);
    localparam logic [c_FILL_W-1:0]   c_FILL_FULL = c_FILL_W'(DELAY);
    localparam logic [c_FILL_W-1:0]   c_FILL_ONE  = c_FILL_W'(1);

`ifdef COMB_DIFF_SATURATE_EN
    localparam logic [WIDTH-1:0]      c_SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]      c_SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // hist_q[0] is the most recent accepted sample, hist_q[DELAY-1] the
    // oldest one still needed, i.e. x[n-DELAY] for the next sample.
    logic [WIDTH-1:0]    hist_q [DELAY];
    logic [WIDTH-1:0]    hist_d [DELAY];
    logic [c_FILL_W-1:0] fill_q;
    logic [c_FILL_W-1:0] fill_d;

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    data_d;
    logic                valid_q;
    logic                valid_d;
    logic                borrow_q;
    logic                borrow_d;
    logic                ovf_q;
    logic                ovf_d;
    logic                warm_q;
    logic                warm_d;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_in_ready;
    logic w_accept;

    // A new sample may enter whenever the output register is empty or is
    // being drained this cycle; clear blocks intake so the flushed history
    // is not immediately refilled by the sample presented alongside it.
    assign w_in_ready = !clear && (!valid_q || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_xd;
    logic [WIDTH:0]   w_diff;
    logic             w_ovf;
    logic             w_borrow;
    logic             w_warm;
    logic [WIDTH-1:0] w_result;

    // History is zeroed on reset/clear, so during warm-up the delayed tap
    // naturally reads as 0 without any extra muxing.
    assign w_xd = hist_q[DELAY-1];

    // Sign-extend both operands by one bit so the difference is exact.
    assign w_diff   = {in_data[WIDTH-1], in_data} - {w_xd[WIDTH-1], w_xd};

    // The true result fits in WIDTH bits only if the two top bits agree.
    assign w_ovf    = w_diff[WIDTH] ^ w_diff[WIDTH-1];
    assign w_borrow = in_data < w_xd;
    assign w_warm   = fill_q < c_FILL_FULL;

`ifdef COMB_DIFF_SATURATE_EN
    // On overflow w_diff[WIDTH] carries the sign of the exact result.
    always_comb begin
        w_result = w_diff[WIDTH-1:0];
        if (w_ovf) begin
            w_result = w_diff[WIDTH] ? c_SAT_MIN : c_SAT_MAX;
        end
    end
`else
    assign w_result = w_diff[WIDTH-1:0];
`endif

    // ------------------------------------------------------------------------
    // History / fill next state
    // ------------------------------------------------------------------------
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            for (int k = 0; k < DELAY; k++) begin
                hist_d[k] = '0;
            end
            fill_d = '0;
        end else if (w_accept) begin
            hist_d[0] = in_data;
            for (int k = 1; k < DELAY; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            // Saturate rather than wrap so out_warm never re-asserts.
            if (fill_q != c_FILL_FULL) begin
                fill_d = fill_q + c_FILL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stage next state
    // ------------------------------------------------------------------------
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        warm_d   = warm_q;
        if (clear) begin
            // Payload is left as-is; only the qualifiers are flushed.
            valid_d  = 1'b0;
            borrow_d = 1'b0;
            ovf_d    = 1'b0;
            warm_d   = 1'b0;
        end else if (w_accept) begin
            // Covers the simultaneous drain-and-reload case: no bubble.
            data_d   = w_result;
            valid_d  = 1'b1;
            borrow_d = w_borrow;
            ovf_d    = w_ovf;
            warm_d   = w_warm;
        end else if (valid_q && out_ready) begin
            valid_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DELAY; k++) begin
                hist_q[k] <= '0;
            end
            fill_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            warm_q   <= 1'b0;
        end else begin
            for (int k = 0; k < DELAY; k++) begin
                hist_q[k] <= hist_d[k];
            end
            fill_q   <= fill_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            warm_q   <= warm_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_borrow = borrow_q;
    assign out_ovf    = ovf_q;
    assign out_warm   = warm_q;

endmodule
`default_nettype wire

// File: tb/tb_comb_differentiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comb_differentiator
//  Description : Self-checking bench for comb_differentiator. One instance
//                with DELAY=1 runs a vector table plus backpressure and
//                asynchronous-reset sequences; one with DELAY=3 runs a ramp
//                and a randomized stream against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comb_differentiator;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: DELAY = 1
    logic         a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic         a_out_borrow, a_out_ovf, a_out_warm;
    logic [W-1:0] a_in_data, a_out_data;

    // Instance B: DELAY = 3
    logic         b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic         b_out_borrow, b_out_ovf, b_out_warm;
    logic [W-1:0] b_in_data, b_out_data;

    comb_differentiator #(.WIDTH(W), .DELAY(1)) u_dut_d1 (
        .clk        (clk),
        .reset      (rst),
        .clear      (a_clear),
        .in_data    (a_in_data),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .out_data   (a_out_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_borrow (a_out_borrow),
        .out_ovf    (a_out_ovf),
        .out_warm   (a_out_warm)
    );

    comb_differentiator #(.WIDTH(W), .DELAY(3)) u_dut_d3 (
        .clk        (clk),
        .reset      (rst),
        .clear      (b_clear),
        .in_data    (b_in_data),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .out_data   (b_out_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_borrow (b_out_borrow),
        .out_ovf    (b_out_ovf),
        .out_warm   (b_out_warm)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Vector table for instance A (DELAY = 1)
    // ------------------------------------------------------------------------
    typedef struct {
        logic         clr;
        logic [W-1:0] x;
        logic         v;
        logic [W-1:0] d;
        logic         b;
        logic         o;
        logic         w;
    } vec_t;

`ifdef COMB_DIFF_SATURATE_EN
    localparam logic [W-1:0] E4 = 16'h8000;  // -32768 - 2 clamps low
    localparam logic [W-1:0] E5 = 16'h7FFF;  //  32767 + 32768 clamps high
`else
    localparam logic [W-1:0] E4 = 16'h7FFE;
    localparam logic [W-1:0] E5 = 16'hFFFF;
`endif

    vec_t tbl [10];

    // ------------------------------------------------------------------------
    // Reference model for instance B: list of samples accepted since the
    // last flush; x[n-3] is the oldest entry once three are stored.
    // ------------------------------------------------------------------------
    localparam int MD = 3;
    logic [W-1:0] hq[$];
    logic         m_valid, m_b, m_o, m_w;
    logic [W-1:0] m_data;

    task automatic model_accept(input logic [W-1:0] x);
        logic [W-1:0] xd;
        int           d;
        xd     = (hq.size() == MD) ? hq[0] : '0;
        d      = int'($signed(x)) - int'($signed(xd));
        m_w    = (hq.size() < MD);
        m_o    = (d > 32767) || (d < -32768);
        m_b    = (x < xd);
`ifdef COMB_DIFF_SATURATE_EN
        if (m_o) m_data = (d > 0) ? 16'h7FFF : 16'h8000;
        else     m_data = W'(d);
`else
        m_data = W'(d);
`endif
        m_valid = 1'b1;
        hq.push_back(x);
        if (hq.size() > MD) void'(hq.pop_front());
    endtask

    logic exp_rdy;

    initial begin
        tbl[0] = '{1'b0, 16'd5,    1'b1, 16'd5,    1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 16'd7,    1'b1, 16'd2,    1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 16'd7,    1'b1, 16'd0,    1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 16'd2,    1'b1, 16'hFFFB, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'h8000, 1'b1, E4,       1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 16'h7FFF, 1'b1, E5,       1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 16'h1234, 1'b0, E5,       1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 16'd9,    1'b1, 16'd9,    1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 16'd9,    1'b1, 16'd0,    1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 16'hFFFF, 1'b1, 16'hFFF6, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  a_out_valid,  0);
        chk("rst_data",   a_out_data,   0);
        chk("rst_borrow", a_out_borrow, 0);
        chk("rst_ovf",    a_out_ovf,    0);
        chk("rst_warm",   a_out_warm,   0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- table on DELAY=1 ----------------
        for (int i = 0; i < 10; i++) begin
            a_clear = tbl[i].clr; a_in_valid = 1'b1; a_in_data = tbl[i].x; a_out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), a_in_ready, !tbl[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i),  a_out_valid,  tbl[i].v);
            chk($sformatf("tbl%0d_data", i),   a_out_data,   tbl[i].d);
            chk($sformatf("tbl%0d_borrow", i), a_out_borrow, tbl[i].b);
            chk($sformatf("tbl%0d_ovf", i),    a_out_ovf,    tbl[i].o);
            chk($sformatf("tbl%0d_warm", i),   a_out_warm,   tbl[i].w);
        end
        a_clear = 1'b0;

        // ---------------- backpressure on DELAY=1 ----------------
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0100;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", a_in_ready, 0);
            @(posedge clk);
            #1;
            chk("bp_valid", a_out_valid, 1);
            chk("bp_data",  a_out_data,  16'hFFF6);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        // History must still hold 0xFFFF: 0x0100 - (-1) = 0x0101.
        chk("rel_valid",  a_out_valid,  1);
        chk("rel_data",   a_out_data,   16'h0101);
        chk("rel_borrow", a_out_borrow, 1);
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", a_out_valid, 0);
        chk("drain_data",  a_out_data,  16'h0101);

        // ---------------- ramp on DELAY=3 ----------------
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1; b_in_data = W'(i + 1); b_out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("ramp%0d_valid", i), b_out_valid, 1);
            chk($sformatf("ramp%0d_data", i),  b_out_data,  (i < 3) ? i + 1 : 3);
            chk($sformatf("ramp%0d_warm", i),  b_out_warm,  (i < 3));
        end
        b_in_valid = 1'b0; b_clear = 1'b1;
        @(posedge clk);
        #1;
        chk("bclr_valid", b_out_valid, 0);
        chk("bclr_warm",  b_out_warm,  0);
        b_clear = 1'b0;

        // ---------------- random on DELAY=3 vs model ----------------
        hq.delete();
        m_valid = 1'b0; m_data = 16'd3; m_b = 1'b0; m_o = 1'b0; m_w = 1'b0;
        for (int i = 0; i < 500; i++) begin
            b_clear     = ($urandom_range(0, 19) == 0);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 9) < 7);
            b_in_data   = W'($urandom);
            if ($urandom_range(0, 7) == 0) b_in_data = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            exp_rdy = !b_clear && (!m_valid || b_out_ready);
            @(negedge clk);
            chk("rnd_in_ready", b_in_ready, exp_rdy);
            if (b_clear) begin
                hq.delete();
                m_valid = 1'b0; m_b = 1'b0; m_o = 1'b0; m_w = 1'b0;
            end else if (b_in_valid && exp_rdy) begin
                model_accept(b_in_data);
            end else if (m_valid && b_out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rnd_valid",  b_out_valid,  m_valid);
            chk("rnd_data",   b_out_data,   m_data);
            chk("rnd_borrow", b_out_borrow, m_b);
            chk("rnd_ovf",    b_out_ovf,    m_o);
            chk("rnd_warm",   b_out_warm,   m_w);
        end
        b_clear = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

        // ---------------- asynchronous reset mid-stream ----------------
        a_in_valid = 1'b1; a_in_data = 16'h0055; a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        // 0x0055 - 0x0100 = -0xAB
        chk("ar_pre_valid",  a_out_valid,  1);
        chk("ar_pre_data",   a_out_data,   16'hFF55);
        chk("ar_pre_borrow", a_out_borrow, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid",   a_out_valid,  0);
        chk("ar_data",    a_out_data,   0);
        chk("ar_borrow",  a_out_borrow, 0);
        chk("ar_ovf",     a_out_ovf,    0);
        chk("ar_warm",    a_out_warm,   0);
        chk("ar_b_valid", b_out_valid,  0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_post_valid", a_out_valid, 1);
        chk("ar_post_data",  a_out_data,  16'h0055);
        chk("ar_post_warm",  a_out_warm,  1);
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comb_differentiator.md
Name: comb_differentiator

Overview:
- Streaming first-difference (comb) stage: y[n] = x[n] - x[n-DELAY] on signed two's-complement samples.
- Inverse operation of the datapath's adder/accumulator path. Used as the comb section downstream of integrator chains (CIC decimation) and for edge/slope detection.
- Valid/ready handshakes on both sides; single registered output stage; one cycle latency.

Parameters:
- WIDTH, 16, sample width in bits (signed, two's complement), 2..32.
- DELAY, 1, differential delay M in samples, 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of history and output stage.
- in_data  input  WIDTH  signed input sample x[n].
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a sample this cycle.
- out_data  output  WIDTH  signed difference y[n].
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_borrow  output  1  unsigned borrow of x[n] - x[n-DELAY], i.e. x < x_d compared as unsigned.
- out_ovf  output  1  signed overflow occurred in the subtraction.
- out_warm  output  1  output computed while history was not yet full (first DELAY samples after reset/clear).

Behaviour:
- Reset (async, active-high): history regs = 0, fill counter = 0, out_data = 0, out_valid = 0, out_borrow = 0, out_ovf = 0, out_warm = 0.
- Interface rules:
  - in_ready = !clear && (!out_valid || out_ready). Combinational, no dependence on in_valid.
  - Accept = in_valid && in_ready.
  - Output handshake completes when out_valid && out_ready.
- On accept:
  - x_d = hist[DELAY-1] (0 during warm-up).
  - Full-precision difference d = sext(x) - sext(x_d), WIDTH+1 bits.
  - out_data <= d[WIDTH-1:0] (wrap).
  - out_ovf <= d[WIDTH] != d[WIDTH-1].
  - out_borrow <= unsigned(x) < unsigned(x_d).
  - out_warm <= (fill < DELAY).
  - out_valid <= 1.
  - History shifts: hist[0] <= x, hist[k] <= hist[k-1].
  - fill <= min(fill+1, DELAY). Fill counter saturates and never wraps.
- Latency: sample accepted in cycle t appears on out_data with out_valid = 1 in cycle t+1.
- Throughput: 1 sample/cycle while out_ready = 1.
- Backpressure (out_valid && !out_ready): out_data and flags are held stable, in_ready = 0, history unchanged.
- Simultaneous output handshake and new accept in the same cycle: the output register reloads with the new result and out_valid stays 1 (no bubble).
- No accept and output handshake completes: out_valid <= 0, out_data holds its last value.
- clear (synchronous, priority over accept):
  - History = 0, fill = 0, out_valid <= 0, flags <= 0.
  - A sample presented in the clear cycle is not accepted (in_ready = 0).
- Reset asserted mid-stream: immediate return to reset state. Any pending output is lost.
- DELAY = 1: history is a single register. Steady-state DC input yields out_data = 0.

Optional Feature:
- Macro COMB_DIFF_SATURATE_EN.
- Defined: on signed overflow, out_data clamps to +2^(WIDTH-1)-1 when d is positive, or -2^(WIDTH-1) when d is negative. out_ovf still reports the overflow.
- Undefined: out_data is the wrapped low WIDTH bits of d.
- All other behaviour, latency and flags are identical in both builds.

Test Plan:
- Reset then stream 5, 7, 7, 2 (DELAY=1, out_ready=1): out_data 5 (warm=1), 2, 0, -5 (0xFFFB). Each result one cycle after its accept. Borrow only on the last.
- DELAY=3, ramp 1,2,3,4,5,6: out_data 1,2,3 with warm=1, then 3,3,3 with warm=0.
- DELAY=1, inputs 0x8000 then 0x7FFF: second result has out_ovf=1. Without macro out_data=0xFFFF; with COMB_DIFF_SATURATE_EN out_data=0x7FFF.
- Hold out_ready=0 for 4 cycles with in_valid=1: in_ready=0, out_data stable, no history advance. Release: next sample accepted same cycle, out_valid stays 1 without bubble.
- Assert clear during streaming with in_valid=1: out_valid=0 next cycle, sample dropped. Next accepted sample 9 outputs 9 with warm=1.
- Assert reset asynchronously mid-stream between clock edges: out_valid, out_data and flags go to 0 immediately. After release, first output has warm=1.
